// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - bus RAM port to asynchronous 32-bit SRAM bridge with programmable wait states
module sram_controller #(
  parameter int ADDR_WIDTH = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [23:0]           ram_addr,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [3:0]            byte_enable,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_o,
  input  logic [31:0]           sram_data_i,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] READ       = 3'd1;
  localparam logic [2:0] WRITE      = 3'd2;
  localparam logic [2:0] WRITE_HOLD = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  localparam int MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] RD_INIT = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WR_INIT = CW'(WRITE_WAIT - 1);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  doe_q, doe_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic [3:0]            be_n_q, be_n_d;

  // Upper bus address bits are intentionally dropped: the SRAM address wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ram_addr[23:ADDR_WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    doe_d   = doe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    be_n_d  = be_n_q;
    case (state_q)
      IDLE: begin
        if (wr) begin
          addr_d  = ram_addr[ADDR_WIDTH-1:0];
          wdata_d = data_i;
          be_n_d  = ~byte_enable;
          ce_n_d  = 1'b0;
          we_n_d  = 1'b0;
          doe_d   = 1'b1;
          cnt_d   = WR_INIT;
          state_d = WRITE;
        end else if (rd) begin
          addr_d  = ram_addr[ADDR_WIDTH-1:0];
          be_n_d  = 4'b0000;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          cnt_d   = RD_INIT;
          state_d = READ;
        end
      end
      READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rdata_d = sram_data_i;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Raise WE first; address/data stay driven one more cycle for hold time.
          we_n_d  = 1'b1;
          state_d = WRITE_HOLD;
        end
      end
      WRITE_HOLD: begin
        ce_n_d  = 1'b1;
        doe_d   = 1'b0;
        be_n_d  = 4'b1111;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'b1111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  assign stall = rst_n & (((state_q == IDLE) & (rd | wr)) |
                          (state_q == READ) | (state_q == WRITE) | (state_q == WRITE_HOLD));

  assign data_o       = rdata_q;
  assign sram_addr    = addr_q;
  assign sram_data_o  = wdata_q;
  assign sram_data_oe = doe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_be_n    = be_n_q;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Bridges the data/instruction bus RAM port (ram_addr, read/write enables, byte enables, ram_stall) to an external asynchronous 32-bit SRAM with programmable wait states.
- Sits directly downstream of the bus decoder and replaces the zero-latency RAM model in the SoC.
- Converts each single bus request into a timed SRAM read or write cycle and holds the bus stalled until the cycle completes.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width; ram_addr bits above ADDR_WIDTH-1 are ignored.
- READ_WAIT, 2, cycles OE_n is held low before read data is sampled (>=1).
- WRITE_WAIT, 2, cycles WE_n is held low per write (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ram_addr  in  24  word address from bus
- data_i  in  32  write data from bus
- data_o  out  32  read data to bus
- rd  in  1  read request, held until stall drops
- wr  in  1  write request, held until stall drops
- byte_enable  in  4  byte lanes for writes; bit n selects data[8n+7:8n]
- stall  out  1  bus stall (combinational)
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_data_o  out  32  data driven to SRAM
- sram_data_i  in  32  data returned by SRAM
- sram_data_oe  out  1  1 = sram_data_o drives the pad
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_be_n  out  4  byte enables, active low

Behaviour:
- Reset is synchronous: clk is the only clock, and rst_n is sampled active-low on the rising edge.
- Reset values:
  - state = IDLE
  - data_o = 0, sram_addr = 0, sram_data_o = 0
  - sram_data_oe = 0, sram_ce_n = 1, sram_oe_n = 1, sram_we_n = 1, sram_be_n = 4'b1111
  - stall is forced to 0 while rst_n = 0.
- Reset asserted mid-operation: the cycle is aborted, all SRAM controls are deasserted at that edge, and no data_o update occurs.
- All SRAM outputs and data_o are registered. stall = (state==IDLE & (rd|wr)) | state in {READ, WRITE, WRITE_HOLD}.
- FSM, IDLE:
  - On wr: latch addr, data_i and ~byte_enable into the SRAM registers; ce_n=0, we_n=0, data_oe=1; counter=WRITE_WAIT-1; go to WRITE.
  - Else on rd: latch addr; ce_n=0, oe_n=0, be_n=0000; counter=READ_WAIT-1; go to READ.
  - wr has priority when rd and wr are both asserted.
- FSM, READ:
  - If counter != 0, decrement.
  - If counter == 0, data_o <= sram_data_i; ce_n=1, oe_n=1; go to DONE.
- FSM, WRITE:
  - If counter != 0, decrement.
  - If counter == 0, we_n=1 while ce_n, addr, data and data_oe are held; go to WRITE_HOLD (data hold time).
- FSM, WRITE_HOLD: ce_n=1, data_oe=0, be_n=1111; go to DONE.
- FSM, DONE: stall=0 regardless of rd/wr, so the bus samples data_o and retires the request. Always go to IDLE. data_o holds its value until the next read completes.
- A request still asserted in the cycle after DONE is treated as a new access (back-to-back support).
- Latency:
  - Read: stall high for READ_WAIT+1 cycles; data_o valid in DONE.
  - Write: stall high for WRITE_WAIT+2 cycles.
- Width rules:
  - sram_addr = ram_addr[ADDR_WIDTH-1:0]; the address wraps silently.
  - A write with byte_enable = 0000 still runs a full cycle with be_n = 1111.
  - Reads always enable all four lanes; the bus performs byte extraction.
- sram_we_n and sram_oe_n are never low simultaneously. data_oe is never 1 while oe_n = 0.

Test Plan:
1. Reset then read, default params: rst_n low 2 cycles, then rd=1, ram_addr=0x000010, SRAM model returns 0xDEADBEEF.
   -> stall high 3 cycles; sram_addr=0x00010; oe_n low 2 cycles; data_o=0xDEADBEEF in DONE, with stall=0.
2. Byte write: wr=1, ram_addr=0x000004, data_i=0x11223344, byte_enable=0101.
   -> be_n=1010; we_n low exactly 2 cycles; data_oe high 3 cycles; stall high 4 cycles; SRAM word 4 updates only lanes 0 and 2.
3. Back-to-back: write 0xCAFEF00D to address 8, then immediately read address 8.
   -> the read returns 0xCAFEF00D; no cycle has we_n=0 and oe_n=0 together.
4. Simultaneous rd=wr=1 at address 3.
   -> a write cycle is performed and data_o is unchanged.
5. Reset mid-read: assert rst_n=0 during the second READ cycle.
   -> next edge gives ce_n=oe_n=1 and state IDLE; stall=0 while reset is held; data_o keeps its reset value 0.
6. Address wrap with READ_WAIT=4: ram_addr=0xF00001.
   -> sram_addr=0x00001; stall high 5 cycles.
